// File: rtl/isa_pkg.sv
// Shared MIPS ISA constants: 6-bit opcodes and funct codes used by both the
// decoder and this encoder, plus the 4-bit command codes driven into the encoder.
package isa_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLTU  = 6'b101011;

   // Command codes presented on cmd_op; 14 and 15 are deliberately unassigned
   typedef enum logic [3:0] {
      CMD_NOP   = 4'd0,
      CMD_ADDU  = 4'd1,
      CMD_SUBU  = 4'd2,
      CMD_AND   = 4'd3,
      CMD_OR    = 4'd4,
      CMD_SLTU  = 4'd5,
      CMD_LW    = 4'd6,
      CMD_SW    = 4'd7,
      CMD_BEQ   = 4'd8,
      CMD_ADDIU = 4'd9,
      CMD_J     = 4'd10,
      CMD_LUI   = 4'd11,
      CMD_ORI   = 4'd12,
      CMD_LI    = 4'd13
   } cmd_op_e;

   // R-type word with shamt fixed at zero
   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
   endfunction

   // I-type word
   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational formatter: turns one symbolic command into its first instruction
// word, the follow-up word for a two-word LI, and flags for two-word / illegal.
module instr_pack
   import isa_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic [31:0] second_word,
   output logic        two_word,
   output logic        illegal
);

   logic [15:0] hi;
   logic [15:0] lo;

   assign hi = imm[31:16];
   assign lo = imm[15:0];

   // Select the encoding for the command; LI picks the shortest expansion that fits
   always_comb begin
      word        = 32'd0;
      second_word = 32'd0;
      two_word    = 1'b0;
      illegal     = 1'b0;
      case (cmd_op_e'(op))
         CMD_NOP:   word = 32'd0;
         CMD_ADDU:  word = rtype(rs, rt, rd, FN_ADDU);
         CMD_SUBU:  word = rtype(rs, rt, rd, FN_SUBU);
         CMD_AND:   word = rtype(rs, rt, rd, FN_AND);
         CMD_OR:    word = rtype(rs, rt, rd, FN_OR);
         CMD_SLTU:  word = rtype(rs, rt, rd, FN_SLTU);
         CMD_LW:    word = itype(OP_LW, rs, rt, lo);
         CMD_SW:    word = itype(OP_SW, rs, rt, lo);
         CMD_BEQ:   word = itype(OP_BEQ, rs, rt, lo);
         CMD_ADDIU: word = itype(OP_ADDIU, rs, rt, lo);
         CMD_J:     word = {OP_J, imm[25:0]};
         CMD_LUI:   word = itype(OP_LUI, 5'd0, rt, lo);
         CMD_ORI:   word = itype(OP_ORI, rs, rt, lo);
         CMD_LI: begin
            if (hi == 16'd0) begin
               word = itype(OP_ORI, 5'd0, rt, lo);
            end else if (lo == 16'd0) begin
               word = itype(OP_LUI, 5'd0, rt, hi);
            end else begin
               word        = itype(OP_LUI, 5'd0, rt, hi);
               second_word = itype(OP_ORI, rt, rt, lo);
               two_word    = 1'b1;
            end
         end
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Command-driven instruction encoder: accepts symbolic commands over valid/ready,
// formats them with instr_pack and streams the words into instruction memory.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [4:0]        cmd_rs,
   input  logic [4:0]        cmd_rt,
   input  logic [4:0]        cmd_rd,
   input  logic [31:0]       cmd_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_e;

   state_e            state;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       pending_word;

   logic [31:0]       pack_word;
   logic [31:0]       pack_second;
   logic              pack_two;
   logic              pack_illegal;

   logic              accept;
   logic              last_slot;
   logic              drop;
   logic              wr_en;
   logic [31:0]       wr_data;

   instr_pack u_pack (
      .op          (cmd_op),
      .rs          (cmd_rs),
      .rt          (cmd_rt),
      .rd          (cmd_rd),
      .imm         (cmd_imm),
      .word        (pack_word),
      .second_word (pack_second),
      .two_word    (pack_two),
      .illegal     (pack_illegal)
   );

   assign cmd_ready = (state == IDLE) && !full && !start;
   assign accept    = cmd_valid && cmd_ready;
   assign last_slot = &ptr;

   // Decide whether this cycle writes a word and which one; a two-word LI that
   // would only half fit is dropped rather than leaving a dangling LUI
   always_comb begin
      wr_en   = 1'b0;
      wr_data = pending_word;
      drop    = 1'b0;
      if (!start) begin
         if (state == SECOND) begin
            wr_en = 1'b1;
         end else if (accept) begin
            if (pack_illegal || (pack_two && last_slot)) begin
               drop = 1'b1;
            end else begin
               wr_en   = 1'b1;
               wr_data = pack_word;
            end
         end
      end
   end

   // FSM, pointer, counters and registered write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ptr          <= '0;
         count        <= '0;
         full         <= 1'b0;
         err          <= 1'b0;
         pending_word <= 32'd0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= 32'd0;
      end else begin
         imem_we <= 1'b0;
         if (start) begin
            state <= IDLE;
            ptr   <= '0;
            count <= '0;
            full  <= 1'b0;
            err   <= 1'b0;
         end else begin
            if (drop) begin
               err <= 1'b1;
            end
            if (wr_en) begin
               imem_we    <= 1'b1;
               imem_addr  <= ptr;
               imem_wdata <= wr_data;
               ptr        <= ptr + 1'b1;
               count      <= count + 1'b1;
               if (last_slot) begin
                  full <= 1'b1;
               end
            end
            if (state == SECOND) begin
               state <= IDLE;
            end else if (wr_en && pack_two) begin
               pending_word <= pack_second;
               state        <= SECOND;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-word memory so the full, wrap and
// one-free-word drop cases are reached quickly.
module tb_instr_encoder;

   localparam int ADDR_W = 2;

   logic              clk;
   logic              reset;
   logic              start;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_op;
   logic [4:0]        cmd_rs;
   logic [4:0]        cmd_rt;
   logic [4:0]        cmd_rd;
   logic [31:0]       cmd_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   int checks;
   int errors;

   instr_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_rs     (cmd_rs),
      .cmd_rt     (cmd_rt),
      .cmd_rd     (cmd_rd),
      .cmd_imm    (cmd_imm),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .count      (count),
      .full       (full),
      .err        (err)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one command for a single clock edge, then withdraw it
   task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] imm);
      cmd_op    = op;
      cmd_rs    = rs;
      cmd_rt    = rt;
      cmd_rd    = rd;
      cmd_imm   = imm;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Idle cycle with no command
   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle restart pulse
   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Check the write port in one go
   task automatic checkWrite(input string tag, input logic we,
                             input logic [31:0] addr, input logic [31:0] data);
      checkOutput({tag, "_we"}, {31'd0, imem_we}, {31'd0, we});
      checkOutput({tag, "_addr"}, {30'd0, imem_addr}, addr);
      checkOutput({tag, "_data"}, imem_wdata, data);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      start     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_rs    = 5'd0;
      cmd_rt    = 5'd0;
      cmd_rd    = 5'd0;
      cmd_imm   = 32'd0;

      // Reset state
      idleCycle();
      idleCycle();
      checkWrite("reset", 1'b0, 32'd0, 32'd0);
      checkOutput("reset_count", {29'd0, count}, 32'd0);
      checkOutput("reset_full", {31'd0, full}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

      // ADDU $3,$1,$2
      applyStimulus(4'd1, 5'd1, 5'd2, 5'd3, 32'd0);
      checkWrite("addu", 1'b1, 32'd0, 32'h00221821);
      checkOutput("addu_count", {29'd0, count}, 32'd1);

      // LW then BEQ back to back
      pulseStart();
      checkOutput("start_count", {29'd0, count}, 32'd0);
      applyStimulus(4'd6, 5'd29, 5'd8, 5'd0, 32'h0000_0004);
      checkWrite("lw", 1'b1, 32'd0, 32'h8FA80004);
      checkOutput("lw_ready", {31'd0, cmd_ready}, 32'd1);
      applyStimulus(4'd8, 5'd1, 5'd2, 5'd0, 32'h0000_FFFF);
      checkWrite("beq", 1'b1, 32'd1, 32'h1022FFFF);

      // Two-word LI, then single-word LI
      pulseStart();
      applyStimulus(4'd13, 5'd0, 5'd9, 5'd0, 32'h12345678);
      checkWrite("li_lui", 1'b1, 32'd0, 32'h3C091234);
      checkOutput("li_stall_ready", {31'd0, cmd_ready}, 32'd0);
      idleCycle();
      checkWrite("li_ori", 1'b1, 32'd1, 32'h35295678);
      checkOutput("li_ready_back", {31'd0, cmd_ready}, 32'd1);
      applyStimulus(4'd13, 5'd0, 5'd4, 5'd0, 32'h0000BEEF);
      checkWrite("li_short", 1'b1, 32'd2, 32'h3404BEEF);
      idleCycle();
      checkWrite("hold", 1'b0, 32'd2, 32'h3404BEEF);
      checkOutput("hold_count", {29'd0, count}, 32'd3);

      // One free word left: two-word LI is dropped
      applyStimulus(4'd13, 5'd0, 5'd9, 5'd0, 32'h12345678);
      checkOutput("li_drop_we", {31'd0, imem_we}, 32'd0);
      checkOutput("li_drop_err", {31'd0, err}, 32'd1);
      checkOutput("li_drop_count", {29'd0, count}, 32'd3);
      checkOutput("li_drop_ready", {31'd0, cmd_ready}, 32'd1);

      // J fills the last word
      applyStimulus(4'd10, 5'd0, 5'd0, 5'd0, 32'h0000_0010);
      checkWrite("j_last", 1'b1, 32'd3, 32'h08000010);
      checkOutput("full_set", {31'd0, full}, 32'd1);
      checkOutput("full_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("full_count", {29'd0, count}, 32'd4);
      applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      checkOutput("full_no_write", {31'd0, imem_we}, 32'd0);
      checkOutput("err_sticky", {31'd0, err}, 32'd1);

      // Restart clears everything
      pulseStart();
      checkOutput("restart_full", {31'd0, full}, 32'd0);
      checkOutput("restart_err", {31'd0, err}, 32'd0);
      checkOutput("restart_count", {29'd0, count}, 32'd0);

      // Illegal op is dropped and err sticks
      applyStimulus(4'd15, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF);
      checkOutput("illegal_we", {31'd0, imem_we}, 32'd0);
      checkOutput("illegal_err", {31'd0, err}, 32'd1);
      applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      checkWrite("nop", 1'b1, 32'd0, 32'h00000000);
      checkOutput("nop_err_sticky", {31'd0, err}, 32'd1);

      // start together with a command: no transfer
      start     = 1'b1;
      cmd_op    = 4'd1;
      cmd_valid = 1'b1;
      #1;
      checkOutput("start_blocks_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
      start     = 1'b0;
      cmd_valid = 1'b0;
      checkOutput("start_cmd_we", {31'd0, imem_we}, 32'd0);
      checkOutput("start_cmd_count", {29'd0, count}, 32'd0);

      // Reset while the ORI of a two-word LI is pending
      applyStimulus(4'd13, 5'd0, 5'd5, 5'd0, 32'hABCD0123);
      checkWrite("mid_lui", 1'b1, 32'd0, 32'h3C05ABCD);
      reset = 1'b0;
      #1;
      checkWrite("mid_reset", 1'b0, 32'd0, 32'd0);
      checkOutput("mid_reset_count", {29'd0, count}, 32'd0);
      checkOutput("mid_reset_full", {31'd0, full}, 32'd0);
      idleCycle();
      checkOutput("mid_reset_no_ori", {31'd0, imem_we}, 32'd0);
      reset = 1'b1;
      idleCycle();
      checkOutput("after_reset_idle_we", {31'd0, imem_we}, 32'd0);
      applyStimulus(4'd2, 5'd4, 5'd5, 5'd6, 32'd0);
      checkWrite("subu_after_reset", 1'b1, 32'd0, 32'h00853023);
      checkOutput("subu_count", {29'd0, count}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Command-driven MIPS instruction encoder, the write-side counterpart of the core's instruction decoder. It accepts symbolic commands (operation, register numbers, immediate) over a valid/ready handshake and packs them into 32-bit instruction words in the format the decoder consumes. It expands the `LI` pseudo-instruction into one or two words, and streams every word into instruction memory through a write port with an internal address counter. It sits between the test/boot loader logic and the instruction memory write port.

## Interface
Parameters:
- `ADDR_W`, default 6: instruction-memory word-address width; depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous restart: pointer to 0, clears `full`/`err`, drops any pending word.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  encoder accepts a command this cycle.
- `cmd_op`  in  4  command code (see Operation).
- `cmd_rs`, `cmd_rt`, `cmd_rd`  in  5 each  register fields.
- `cmd_imm`  in  32  immediate: [15:0] for I-type, [25:0] for J, all 32 bits for LI.
- `imem_we`  out  1  instruction-memory write strobe (registered).
- `imem_addr`  out  ADDR_W  word address of the write (registered).
- `imem_wdata`  out  32  encoded instruction (registered).
- `count`  out  ADDR_W+1  number of words written since reset/start.
- `full`  out  1  all 2^ADDR_W words written.
- `err`  out  1  sticky: an illegal op or a non-fitting LI was dropped.

## Operation
- `cmd_op` codes:
  - 0 NOP produces 0x00000000.
  - R-type, op 000000, shamt 0: 1 ADDU (funct 100001), 2 SUBU (100011), 3 AND (100100), 4 OR (100101), 5 SLTU (101011). Format op|rs|rt|rd|shamt|funct.
  - I-type, format op|rs|rt|imm16: 6 LW (100011), 7 SW (101011), 8 BEQ (000100), 9 ADDIU (001001), 11 LUI (001111, rs forced 0), 12 ORI (001101).
  - 10 J (000010): op|imm[25:0].
  - 13 LI rt,imm32:
    - imm[31:16]==0 gives a single `ORI rt,$0,lo`.
    - else imm[15:0]==0 gives a single `LUI rt,hi`.
    - else two words: `LUI rt,hi`, then `ORI rt,rt,lo`.
  - 14, 15 are illegal.
- Handshake: transfer when `cmd_valid && cmd_ready`. `cmd_ready = (state==IDLE) && !full && !start`. Command fields are sampled only on transfer.
- FSM states:
  - IDLE: accept a command.
    - Single-word command: write next cycle, stay in IDLE.
    - Two-word LI: write LUI next cycle, go to SECOND.
  - SECOND: ORI word held internally; write it this cycle, return to IDLE; `cmd_ready`=0.
- Pointer increments by 1 after each write; `count` increments with it.
- After a write to address 2^ADDR_W−1: `full`=1, pointer wraps to 0 but no further writes occur until `start`.
- Drops (command consumed, nothing written, `err` set to 1):
  - Illegal op.
  - Two-word LI accepted with exactly one free word.
- `start` has priority over everything except reset. It aborts SECOND (ORI not written) and clears pointer, `count`, `full`, `err`.

## Timing
- Latency: command accepted in cycle N gives `imem_we`=1 with addr/data in cycle N+1. For a two-word LI, the ORI follows in N+2.
- Throughput: 1 word/cycle for back-to-back single-word commands. A two-word LI stalls `cmd_ready` for one cycle.
- `imem_we` is a single-cycle pulse per word. addr/data hold their last value when `imem_we`=0.
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `count`=0, `full`=0, `err`=0, state IDLE. `cmd_ready`=1 once reset is released.
- Reset mid-LI (in SECOND): all outputs return to reset values immediately; the ORI word is never written.
- `start` and `cmd_valid` in the same cycle: no transfer (`cmd_ready`=0); restart takes effect at the edge.

## Structure
- Shared package `isa_pkg`:
  - 6-bit opcode constants and funct constants (shared with the decoder).
  - The 4-bit `cmd_op` code constants.
- Sub-module `instr_pack`: purely combinational word formatter taking op/rs/rt/rd/imm to a 32-bit word plus `two_word` and `illegal` flags. The top level contains the FSM, pointer, counters and output registers.

## Test plan
- ADDU rs=1 rt=2 rd=3 after reset → cycle+1: `imem_we`=1, addr 0, data 0x00221821; `count`=1.
- LW rs=29 rt=8 imm=0x0004, then BEQ rs=1 rt=2 imm=0xFFFF back-to-back → 0x8FA80004 @0, 0x1022FFFF @1; `cmd_ready` stays 1.
- LI rt=9 imm=0x12345678 → 0x3C091234 @0, then 0x35295678 @1; `cmd_ready`=0 for one cycle. LI rt=4 imm=0x0000BEEF → single 0x3404BEEF.
- J imm=0x0000010 → 0x08000010. Op 15 → no write, `err`=1 and stays 1 until `start`.
- ADDR_W=2: three NOPs, then two-word LI → dropped, `err`=1. Next NOP → addr 3, `full`=1, `cmd_ready`=0. `start` → `full`=0, `err`=0, `count`=0, next write at addr 0.
- Assert `reset` during SECOND of a two-word LI → no ORI write; `imem_we`, `count`, `full` = 0 at once. After release the first command writes addr 0.
